// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: data width helper, mcause values and FSM states.
// The optional counters are enabled with the TRAP_SEQ_STATS_EN macro in trap_sequencer.sv.
package trap_sequencer_pkg;

   localparam logic [1:0] XLEN_32b = 2'd1;
   localparam logic [1:0] XLEN_64b = 2'd2;

   // The data width follows the 2-bit XLEN code: 1 -> 32, 2 -> 64.
   function automatic int xlen_width(input logic [1:0] xlen);
      return 1 << (int'(xlen) + 4);
   endfunction

   // mcause 10 is reserved, so it doubles as the "nothing pending" marker.
   localparam logic [3:0] NO_EXC                 = 4'd10;
   localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
   localparam logic [3:0] CAUSE_INSTR_FAULT      = 4'd1;
   localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
   localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;
   localparam logic [3:0] CAUSE_ECALL_U          = 4'd8;
   localparam logic [3:0] CAUSE_ECALL_S          = 4'd9;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_HOLDOFF  = 2'd3
   } trap_state_t;

endpackage

// File: rtl/trap_sequencer_priority_encoder.sv
// Picks the single winning event among E/M exception, F/D exception, ecall and mret,
// and forms the code, PC and address to be latched for it.
module trap_priority_encoder
   import trap_sequencer_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         exc_valid_fd,
   input  logic [3:0]   exc_code_fd,
   input  logic [W-1:0] pc_fd,
   input  logic         ecall,
   input  logic         mret,
   input  logic         exc_valid_em,
   input  logic [3:0]   exc_code_em,
   input  logic [W-1:0] pc_em,
   input  logic [W-1:0] addr_em,
   input  logic [1:0]   privilege,
   output logic         accept,
   output logic         sel_em,
   output logic         is_mret,
   output logic [3:0]   code,
   output logic [W-1:0] pc,
   output logic [W-1:0] addr
);

   logic req_em;
   logic req_fd;

   // A valid flag carrying the NO_EXC code is not a request.
   assign req_em = exc_valid_em && (exc_code_em != NO_EXC);
   assign req_fd = exc_valid_fd && (exc_code_fd != NO_EXC);

   // The older E/M instruction wins over anything younger in the pipe.
   always_comb begin
      accept  = 1'b0;
      sel_em  = 1'b0;
      is_mret = 1'b0;
      code    = NO_EXC;
      pc      = '0;
      addr    = '0;
      if (req_em) begin
         accept = 1'b1;
         sel_em = 1'b1;
         code   = exc_code_em;
         pc     = pc_em;
         addr   = addr_em;
      end else if (req_fd) begin
         accept = 1'b1;
         code   = exc_code_fd;
         pc     = pc_fd;
      end else if (ecall) begin
         accept = 1'b1;
         code   = CAUSE_ECALL_U + {2'b00, privilege};
         pc     = pc_fd;
      end else if (mret) begin
         accept  = 1'b1;
         is_mret = 1'b1;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Serialises exceptions, ecall and mret into one trap/return at a time toward the CSR unit.
// Define TRAP_SEQ_STATS_EN to add the o_trap_count / o_mret_count statistics outputs.
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter  logic [1:0] XLEN = XLEN_64b,
   localparam int         W    = xlen_width(XLEN)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clk_en,
   input  logic         i_exc_valid_fd,
   input  logic [3:0]   i_exc_code_fd,
   input  logic [W-1:0] i_pc_fd,
   input  logic         i_ecall_d,
   input  logic         i_mret_d,
   input  logic         i_exc_valid_em,
   input  logic [3:0]   i_exc_code_em,
   input  logic [W-1:0] i_pc_em,
   input  logic [W-1:0] i_addr_em,
   input  logic [1:0]   i_current_privilege,
   input  logic [W-1:0] i_mtvec,
   input  logic [W-1:0] i_mepc,
   input  logic         i_disable_exceptions_1cc,
   output logic [3:0]   o_exception_code_f_d_ff,
   output logic [W-1:0] o_exception_pc_f_d_ff,
   output logic [3:0]   o_exception_code_e_m_ff,
   output logic [W-1:0] o_exception_pc_e_m_ff,
   output logic [W-1:0] o_exception_addr_e_m_ff,
   output logic         o_mret_e,
   output logic         o_flush,
   output logic         o_stall,
   output logic         o_redirect_valid,
   output logic [W-1:0] o_redirect_pc,
`ifdef TRAP_SEQ_STATS_EN
   output logic [31:0]  o_trap_count,
   output logic [31:0]  o_mret_count,
`endif
   output logic         o_busy
);

   trap_state_t  state, state_next;

   logic [3:0]   code_fd, code_fd_next;
   logic [W-1:0] pc_fd, pc_fd_next;
   logic [3:0]   code_em, code_em_next;
   logic [W-1:0] pc_em, pc_em_next;
   logic [W-1:0] addr_em, addr_em_next;
   logic         mret_e, mret_next;
   logic         kind_mret, kind_mret_next;

   logic         ev_accept;
   logic         ev_sel_em;
   logic         ev_is_mret;
   logic [3:0]   ev_code;
   logic [W-1:0] ev_pc;
   logic [W-1:0] ev_addr;
   logic [W-1:0] mtvec_base;
   logic         start_event;

   trap_priority_encoder #(
      .W (W)
   ) u_priority (
      .exc_valid_fd (i_exc_valid_fd),
      .exc_code_fd  (i_exc_code_fd),
      .pc_fd        (i_pc_fd),
      .ecall        (i_ecall_d),
      .mret         (i_mret_d),
      .exc_valid_em (i_exc_valid_em),
      .exc_code_em  (i_exc_code_em),
      .pc_em        (i_pc_em),
      .addr_em      (i_addr_em),
      .privilege    (i_current_privilege),
      .accept       (ev_accept),
      .sel_em       (ev_sel_em),
      .is_mret      (ev_is_mret),
      .code         (ev_code),
      .pc           (ev_pc),
      .addr         (ev_addr)
   );

   assign start_event = (state == ST_IDLE) && ev_accept;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state     <= ST_IDLE;
         code_fd   <= NO_EXC;
         pc_fd     <= '0;
         code_em   <= NO_EXC;
         pc_em     <= '0;
         addr_em   <= '0;
         mret_e    <= 1'b0;
         kind_mret <= 1'b0;
      end else if (i_clk_en) begin
         state     <= state_next;
         code_fd   <= code_fd_next;
         pc_fd     <= pc_fd_next;
         code_em   <= code_em_next;
         pc_em     <= pc_em_next;
         addr_em   <= addr_em_next;
         mret_e    <= mret_next;
         kind_mret <= kind_mret_next;
      end
   end

   // Only the winning event's port is loaded; simultaneous losers are dropped, not queued.
   always_comb begin
      state_next     = state;
      code_fd_next   = code_fd;
      pc_fd_next     = pc_fd;
      code_em_next   = code_em;
      pc_em_next     = pc_em;
      addr_em_next   = addr_em;
      mret_next      = mret_e;
      kind_mret_next = kind_mret;
      case (state)
         ST_IDLE: begin
            if (ev_accept) begin
               state_next     = ST_COMMIT;
               mret_next      = ev_is_mret;
               kind_mret_next = ev_is_mret;
               if (ev_sel_em) begin
                  code_em_next = ev_code;
                  pc_em_next   = ev_pc;
                  addr_em_next = ev_addr;
               end else if (!ev_is_mret) begin
                  code_fd_next = ev_code;
                  pc_fd_next   = ev_pc;
               end
            end
         end
         ST_COMMIT: begin
            state_next   = ST_REDIRECT;
            code_fd_next = NO_EXC;
            code_em_next = NO_EXC;
            mret_next    = 1'b0;
         end
         ST_REDIRECT: begin
            state_next = ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            if (!i_disable_exceptions_1cc) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // mepc is read live in REDIRECT so the value written during COMMIT is the one used.
   assign mtvec_base = i_mtvec & ~{{(W-2){1'b0}}, 2'b11};

   assign o_redirect_valid = (state == ST_REDIRECT);
   assign o_redirect_pc    = (state != ST_REDIRECT) ? '0 :
                             (kind_mret ? i_mepc : mtvec_base);
   assign o_flush          = (state == ST_COMMIT) || (state == ST_REDIRECT);
   assign o_stall          = (state == ST_COMMIT) || (state == ST_REDIRECT);
   assign o_busy           = (state != ST_IDLE);

   assign o_exception_code_f_d_ff = code_fd;
   assign o_exception_pc_f_d_ff   = pc_fd;
   assign o_exception_code_e_m_ff = code_em;
   assign o_exception_pc_e_m_ff   = pc_em;
   assign o_exception_addr_e_m_ff = addr_em;
   assign o_mret_e                = mret_e;

`ifdef TRAP_SEQ_STATS_EN
   logic [31:0] trap_count;
   logic [31:0] mret_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         trap_count <= '0;
         mret_count <= '0;
      end else if (i_clk_en && start_event) begin
         if (ev_is_mret) begin
            mret_count <= mret_count + 32'd1;
         end else begin
            trap_count <= trap_count + 32'd1;
         end
      end
   end

   assign o_trap_count = trap_count;
   assign o_mret_count = mret_count;
`else
   logic unused_start;
   assign unused_start = start_event;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed vector table, hand sequences,
// then randomized traffic checked every cycle against a timeline model.
module tb_trap_sequencer;

   localparam int W = 64;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_clk_en;
   logic         i_exc_valid_fd;
   logic [3:0]   i_exc_code_fd;
   logic [W-1:0] i_pc_fd;
   logic         i_ecall_d;
   logic         i_mret_d;
   logic         i_exc_valid_em;
   logic [3:0]   i_exc_code_em;
   logic [W-1:0] i_pc_em;
   logic [W-1:0] i_addr_em;
   logic [1:0]   i_current_privilege;
   logic [W-1:0] i_mtvec;
   logic [W-1:0] i_mepc;
   logic         i_disable_exceptions_1cc;
   logic [3:0]   o_exception_code_f_d_ff;
   logic [W-1:0] o_exception_pc_f_d_ff;
   logic [3:0]   o_exception_code_e_m_ff;
   logic [W-1:0] o_exception_pc_e_m_ff;
   logic [W-1:0] o_exception_addr_e_m_ff;
   logic         o_mret_e;
   logic         o_flush;
   logic         o_stall;
   logic         o_redirect_valid;
   logic [W-1:0] o_redirect_pc;
   logic         o_busy;
`ifdef TRAP_SEQ_STATS_EN
   logic [31:0]  o_trap_count;
   logic [31:0]  o_mret_count;
`endif

   trap_sequencer dut (
      .i_clk                    (i_clk),
      .i_rst                    (i_rst),
      .i_clk_en                 (i_clk_en),
      .i_exc_valid_fd           (i_exc_valid_fd),
      .i_exc_code_fd            (i_exc_code_fd),
      .i_pc_fd                  (i_pc_fd),
      .i_ecall_d                (i_ecall_d),
      .i_mret_d                 (i_mret_d),
      .i_exc_valid_em           (i_exc_valid_em),
      .i_exc_code_em            (i_exc_code_em),
      .i_pc_em                  (i_pc_em),
      .i_addr_em                (i_addr_em),
      .i_current_privilege      (i_current_privilege),
      .i_mtvec                  (i_mtvec),
      .i_mepc                   (i_mepc),
      .i_disable_exceptions_1cc (i_disable_exceptions_1cc),
      .o_exception_code_f_d_ff  (o_exception_code_f_d_ff),
      .o_exception_pc_f_d_ff    (o_exception_pc_f_d_ff),
      .o_exception_code_e_m_ff  (o_exception_code_e_m_ff),
      .o_exception_pc_e_m_ff    (o_exception_pc_e_m_ff),
      .o_exception_addr_e_m_ff  (o_exception_addr_e_m_ff),
      .o_mret_e                 (o_mret_e),
      .o_flush                  (o_flush),
      .o_stall                  (o_stall),
      .o_redirect_valid         (o_redirect_valid),
      .o_redirect_pc            (o_redirect_pc),
`ifdef TRAP_SEQ_STATS_EN
      .o_trap_count             (o_trap_count),
      .o_mret_count             (o_mret_count),
`endif
      .o_busy                   (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic         rst;
      logic         clk_en;
      logic         v_fd;
      logic [3:0]   c_fd;
      logic [W-1:0] pc_fd;
      logic         ecall;
      logic         mret;
      logic         v_em;
      logic [3:0]   c_em;
      logic [W-1:0] pc_em;
      logic [W-1:0] addr_em;
      logic [1:0]   priv;
      logic [W-1:0] mtvec;
      logic [W-1:0] mepc;
      logic         dis;
   } stim_t;

   typedef struct {
      string        name;
      stim_t        s;
      bit           accept;
      logic [3:0]   code_fd;
      logic [W-1:0] pc_fd;
      logic [3:0]   code_em;
      logic [W-1:0] pc_em;
      logic [W-1:0] addr_em;
      bit           mret;
      logic [W-1:0] redir;
   } vec_t;

   typedef struct {
      int           kind;
      logic [3:0]   code;
      logic [W-1:0] pc;
      logic [W-1:0] addr;
   } cand_t;

   int passed = 0;
   int total  = 0;

   // Timeline model: age counts cycles since an event was taken (0 = idle).
   int           m_age;
   logic [3:0]   m_code_fd, m_code_em;
   logic [W-1:0] m_pc_fd, m_pc_em, m_addr_em;
   logic         m_mret, m_kind_mret;
   int unsigned  m_traps, m_mrets;

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic applyStimulus(input stim_t s);
      i_rst                    = s.rst;
      i_clk_en                 = s.clk_en;
      i_exc_valid_fd           = s.v_fd;
      i_exc_code_fd            = s.c_fd;
      i_pc_fd                  = s.pc_fd;
      i_ecall_d                = s.ecall;
      i_mret_d                 = s.mret;
      i_exc_valid_em           = s.v_em;
      i_exc_code_em            = s.c_em;
      i_pc_em                  = s.pc_em;
      i_addr_em                = s.addr_em;
      i_current_privilege      = s.priv;
      i_mtvec                  = s.mtvec;
      i_mepc                   = s.mepc;
      i_disable_exceptions_1cc = s.dis;
   endtask

   function automatic stim_t baseStim();
      stim_t s;
      s        = '0;
      s.rst    = 1'b1;
      s.clk_en = 1'b1;
      s.c_fd   = 4'd10;
      s.c_em   = 4'd10;
      s.priv   = 2'd3;
      s.mtvec  = 64'h8000_0101;
      s.mepc   = 64'h8000_0044;
      return s;
   endfunction

   function automatic stim_t quiet(input stim_t s);
      stim_t q;
      q       = s;
      q.v_fd  = 1'b0;
      q.v_em  = 1'b0;
      q.ecall = 1'b0;
      q.mret  = 1'b0;
      return q;
   endfunction

   task automatic modelEdge();
      cand_t q[$];
      cand_t c;
      if (!i_rst) begin
         m_age = 0; m_code_fd = 4'd10; m_code_em = 4'd10;
         m_pc_fd = '0; m_pc_em = '0; m_addr_em = '0;
         m_mret = 1'b0; m_kind_mret = 1'b0; m_traps = 0; m_mrets = 0;
         return;
      end
      if (!i_clk_en) return;
      if (m_age == 0) begin
         if (i_exc_valid_em && i_exc_code_em != 4'd10) q.push_back('{0, i_exc_code_em, i_pc_em, i_addr_em});
         if (i_exc_valid_fd && i_exc_code_fd != 4'd10) q.push_back('{1, i_exc_code_fd, i_pc_fd, {W{1'b0}}});
         if (i_ecall_d) q.push_back('{1, 4'(8 + int'(i_current_privilege)), i_pc_fd, {W{1'b0}}});
         if (i_mret_d) q.push_back('{2, 4'd10, {W{1'b0}}, {W{1'b0}}});
         if (q.size() > 0) begin
            c = q[0];
            m_age = 1;
            m_kind_mret = (c.kind == 2);
            m_mret = (c.kind == 2);
            if (c.kind == 0) begin
               m_code_em = c.code; m_pc_em = c.pc; m_addr_em = c.addr;
            end else if (c.kind == 1) begin
               m_code_fd = c.code; m_pc_fd = c.pc;
            end
            if (c.kind == 2) m_mrets++;
            else m_traps++;
         end
      end else if (m_age == 1) begin
         m_code_fd = 4'd10; m_code_em = 4'd10; m_mret = 1'b0; m_age = 2;
      end else if (m_age == 2) begin
         m_age = 3;
      end else if (!i_disable_exceptions_1cc) begin
         m_age = 0;
      end
   endtask

   task automatic checkModel();
      logic [W-1:0] exp_redir;
      exp_redir = (m_age != 2) ? '0 : (m_kind_mret ? i_mepc : (i_mtvec & ~64'h3));
      checkOutput("m_busy",   o_busy, m_age != 0);
      checkOutput("m_flush",  o_flush, m_age == 1 || m_age == 2);
      checkOutput("m_stall",  o_stall, m_age == 1 || m_age == 2);
      checkOutput("m_rvalid", o_redirect_valid, m_age == 2);
      checkOutput("m_rpc",    o_redirect_pc, exp_redir);
      checkOutput("m_codefd", o_exception_code_f_d_ff, m_code_fd);
      checkOutput("m_pcfd",   o_exception_pc_f_d_ff, m_pc_fd);
      checkOutput("m_codeem", o_exception_code_e_m_ff, m_code_em);
      checkOutput("m_pcem",   o_exception_pc_e_m_ff, m_pc_em);
      checkOutput("m_addrem", o_exception_addr_e_m_ff, m_addr_em);
      checkOutput("m_mret",   o_mret_e, m_mret);
`ifdef TRAP_SEQ_STATS_EN
      checkOutput("m_ntrap",  o_trap_count, m_traps);
      checkOutput("m_nmret",  o_mret_count, m_mrets);
`endif
   endtask

   task automatic tick();
      modelEdge();
      @(posedge i_clk);
      #1;
      checkModel();
   endtask

   function automatic vec_t mkVec(input string name, input stim_t s, input bit accept,
                                  input logic [3:0] code_fd, input logic [W-1:0] pc_fd,
                                  input logic [3:0] code_em, input logic [W-1:0] pc_em,
                                  input logic [W-1:0] addr_em, input bit mret,
                                  input logic [W-1:0] redir);
      vec_t v;
      v.name = name; v.s = s; v.accept = accept;
      v.code_fd = code_fd; v.pc_fd = pc_fd; v.code_em = code_em;
      v.pc_em = pc_em; v.addr_em = addr_em; v.mret = mret; v.redir = redir;
      return v;
   endfunction

   vec_t vecs[9];

   initial begin
      stim_t s;

      s = baseStim(); s.v_fd = 1; s.c_fd = 4'd2; s.pc_fd = 64'h8000_0010;
      vecs[0] = mkVec("fd_illegal", s, 1, 4'd2, 64'h8000_0010, 4'd10, 0, 0, 0, 64'h8000_0100);
      s = baseStim(); s.v_fd = 1; s.c_fd = 4'd2; s.pc_fd = 64'h8000_0010;
      s.v_em = 1; s.c_em = 4'd5; s.pc_em = 64'h8000_0020; s.addr_em = 64'h1003;
      vecs[1] = mkVec("em_wins", s, 1, 4'd10, 0, 4'd5, 64'h8000_0020, 64'h1003, 0, 64'h8000_0100);
      s = baseStim(); s.ecall = 1; s.priv = 2'd0; s.pc_fd = 64'h8000_0030;
      vecs[2] = mkVec("ecall_u", s, 1, 4'd8, 64'h8000_0030, 4'd10, 0, 0, 0, 64'h8000_0100);
      s = baseStim(); s.ecall = 1; s.priv = 2'd3; s.pc_fd = 64'h8000_0034;
      vecs[3] = mkVec("ecall_m", s, 1, 4'd11, 64'h8000_0034, 4'd10, 0, 0, 0, 64'h8000_0100);
      s = baseStim(); s.mret = 1;
      vecs[4] = mkVec("mret", s, 1, 4'd10, 0, 4'd10, 0, 0, 1, 64'h8000_0044);
      s = baseStim(); s.v_fd = 1; s.c_fd = 4'd10;
      vecs[5] = mkVec("noexc_fd", s, 0, 4'd10, 0, 4'd10, 0, 0, 0, 0);
      s = baseStim(); s.v_em = 1; s.c_em = 4'd10; s.v_fd = 1; s.c_fd = 4'd1; s.pc_fd = 64'h8000_0040;
      vecs[6] = mkVec("noexc_em_fd", s, 1, 4'd1, 64'h8000_0040, 4'd10, 0, 0, 0, 64'h8000_0100);
      s = baseStim(); s.ecall = 1; s.mret = 1; s.priv = 2'd0; s.pc_fd = 64'h8000_0048;
      vecs[7] = mkVec("ecall_over_mret", s, 1, 4'd8, 64'h8000_0048, 4'd10, 0, 0, 0, 64'h8000_0100);
      s = baseStim(); s.v_em = 1; s.c_em = 4'd7; s.pc_em = 64'h8000_0050; s.addr_em = 64'h2006;
      s.mtvec = 64'h8000_0203;
      vecs[8] = mkVec("em_store_fault", s, 1, 4'd10, 0, 4'd7, 64'h8000_0050, 64'h2006, 0, 64'h8000_0200);

      // Reset for two cycles.
      s = baseStim(); s.rst = 0;
      applyStimulus(s);
      tick();
      tick();
      checkOutput("rst_code_fd", o_exception_code_f_d_ff, 4'd10);
      checkOutput("rst_code_em", o_exception_code_e_m_ff, 4'd10);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_redirect", o_redirect_valid, 0);
      checkOutput("rst_pc_em", o_exception_pc_e_m_ff, 0);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].s);
         tick();
         if (vecs[i].accept) begin
            checkOutput({vecs[i].name, "_busy"}, o_busy, 1);
            checkOutput({vecs[i].name, "_flush"}, o_flush, 1);
            checkOutput({vecs[i].name, "_code_fd"}, o_exception_code_f_d_ff, vecs[i].code_fd);
            checkOutput({vecs[i].name, "_code_em"}, o_exception_code_e_m_ff, vecs[i].code_em);
            checkOutput({vecs[i].name, "_mret"}, o_mret_e, vecs[i].mret);
            if (vecs[i].code_fd != 4'd10)
               checkOutput({vecs[i].name, "_pc_fd"}, o_exception_pc_f_d_ff, vecs[i].pc_fd);
            if (vecs[i].code_em != 4'd10) begin
               checkOutput({vecs[i].name, "_pc_em"}, o_exception_pc_e_m_ff, vecs[i].pc_em);
               checkOutput({vecs[i].name, "_addr_em"}, o_exception_addr_e_m_ff, vecs[i].addr_em);
            end
            applyStimulus(quiet(vecs[i].s));
            tick();
            checkOutput({vecs[i].name, "_rvalid"}, o_redirect_valid, 1);
            checkOutput({vecs[i].name, "_rpc"}, o_redirect_pc, vecs[i].redir);
            checkOutput({vecs[i].name, "_mret_clr"}, o_mret_e, 0);
            checkOutput({vecs[i].name, "_code_clr"}, o_exception_code_f_d_ff, 4'd10);
            tick();
            tick();
            checkOutput({vecs[i].name, "_idle"}, o_busy, 0);
         end else begin
            checkOutput({vecs[i].name, "_busy"}, o_busy, 0);
            checkOutput({vecs[i].name, "_code_fd"}, o_exception_code_f_d_ff, 4'd10);
            applyStimulus(quiet(vecs[i].s));
            tick();
         end
      end

      // Holdoff held for extra cycles while a new request is pending: it must be ignored.
      s = baseStim(); s.v_fd = 1; s.c_fd = 4'd2; s.pc_fd = 64'h8000_0060;
      applyStimulus(s); tick();
      applyStimulus(quiet(s)); tick();
      s = baseStim(); s.dis = 1; s.v_em = 1; s.c_em = 4'd4; s.pc_em = 64'h8000_0070;
      applyStimulus(s); tick();
      checkOutput("hold_busy", o_busy, 1);
      checkOutput("hold_flush", o_flush, 0);
      checkOutput("hold_stall", o_stall, 0);
      tick();
      tick();
      checkOutput("hold_code_em", o_exception_code_e_m_ff, 4'd10);
      checkOutput("hold_still_busy", o_busy, 1);
      applyStimulus(baseStim()); tick();
      checkOutput("hold_exit", o_busy, 0);
      tick();
      checkOutput("hold_no_commit", o_busy, 0);

      // Clock enable dropped during COMMIT freezes everything.
      s = baseStim(); s.v_fd = 1; s.c_fd = 4'd1; s.pc_fd = 64'h8000_0080;
      applyStimulus(s); tick();
      s = baseStim(); s.clk_en = 0;
      applyStimulus(s);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("freeze_busy", o_busy, 1);
         checkOutput("freeze_code_fd", o_exception_code_f_d_ff, 4'd1);
         checkOutput("freeze_rvalid", o_redirect_valid, 0);
      end
      applyStimulus(baseStim()); tick();
      checkOutput("unfreeze_rvalid", o_redirect_valid, 1);
      tick(); tick();

      // Reset mid-sequence aborts with no redirect.
      s = baseStim(); s.v_em = 1; s.c_em = 4'd6; s.pc_em = 64'h8000_0090; s.addr_em = 64'h3001;
      applyStimulus(s); tick();
      s = baseStim(); s.rst = 0;
      applyStimulus(s); tick();
      checkOutput("abort_busy", o_busy, 0);
      checkOutput("abort_code_em", o_exception_code_e_m_ff, 4'd10);
      checkOutput("abort_pc_em", o_exception_pc_e_m_ff, 0);
      applyStimulus(baseStim()); tick();
      checkOutput("abort_rvalid", o_redirect_valid, 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         s = baseStim();
         s.rst     = ($urandom_range(0, 49) != 0);
         s.clk_en  = ($urandom_range(0, 9) != 0);
         s.v_fd    = ($urandom_range(0, 4) == 0);
         s.c_fd    = ($urandom_range(0, 3) == 3) ? 4'd10 : 4'($urandom_range(0, 2));
         s.pc_fd   = {32'h0, $urandom};
         s.ecall   = ($urandom_range(0, 7) == 0);
         s.mret    = ($urandom_range(0, 7) == 0);
         s.v_em    = ($urandom_range(0, 4) == 0);
         s.c_em    = ($urandom_range(0, 4) == 4) ? 4'd10 : 4'($urandom_range(4, 7));
         s.pc_em   = {32'h0, $urandom};
         s.addr_em = {$urandom, $urandom};
         s.priv    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
         s.mtvec   = {32'h0, $urandom};
         s.mepc    = {32'h0, $urandom};
         s.dis     = ($urandom_range(0, 2) == 0);
         applyStimulus(s);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Initiator side of the exception/return interface into the CSR unit.
- Collects synchronous exception requests from the F/D and E/M pipeline boundaries, plus decoded ecall/mret, and serialises them into one trap or return at a time.
- Registers the exception code, PC and address presented to the machine CSR register file.
- Drives the pipeline flush and the PC redirect to mtvec or mepc.

Parameters:
- XLEN, `XLEN_64b, 2-bit width code; data width W = 1<<(XLEN+4).
- NO_EXC, 4'd10, sentinel exception code meaning "no exception". Chosen because mcause 10 is reserved.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-low
- i_clk_en  in  1  global clock enable; all state holds when low
- i_exc_valid_fd  in  1  F/D-stage exception request
- i_exc_code_fd  in  4  cause: instr misaligned 0, instr fault 1, illegal 2
- i_pc_fd  in  W  PC of the faulting F/D instruction
- i_ecall_d  in  1  ecall decoded (from CSR unit)
- i_mret_d  in  1  mret decoded (from CSR unit)
- i_exc_valid_em  in  1  E/M-stage exception request
- i_exc_code_em  in  4  cause: load misaligned 4, load fault 5, store misaligned 6, store fault 7
- i_pc_em  in  W  PC of the faulting E/M instruction
- i_addr_em  in  W  faulting data address
- i_current_privilege  in  2  current privilege (U=0, M=3)
- i_mtvec  in  W  mtvec CSR value
- i_mepc  in  W  mepc CSR value (CSR unit o_mepc)
- i_disable_exceptions_1cc  in  1  CSR unit holdoff
- o_exception_code_f_d_ff  out  4  to CSR unit
- o_exception_pc_f_d_ff  out  W  to CSR unit
- o_exception_code_e_m_ff  out  4  to CSR unit
- o_exception_pc_e_m_ff  out  W  to CSR unit
- o_exception_addr_e_m_ff  out  W  to CSR unit
- o_mret_e  out  1  to CSR unit
- o_flush  out  1  flush F/D/E stages
- o_stall  out  1  freeze PC and F/D
- o_redirect_valid  out  1  PC redirect strobe
- o_redirect_pc  out  W  redirect target
- o_busy  out  1  FSM not IDLE

Behaviour:
- Reset (i_rst==0 at a clock edge):
  - Both code outputs = NO_EXC.
  - All PC/addr outputs = 0.
  - o_mret_e, o_flush, o_stall, o_redirect_valid = 0; o_redirect_pc = 0; o_busy = 0.
  - FSM = IDLE.
  - Reset mid-sequence aborts without emitting a redirect.
- i_clk_en low: all registers hold and outputs keep their values.
- FSM states: IDLE, COMMIT, REDIRECT, HOLDOFF.
- IDLE, event priority (highest first):
  - E/M exception (older instruction wins).
  - F/D exception.
  - ecall: code = 8 + i_current_privilege (U→8, M→11), captured on the F/D port.
  - mret.
- IDLE, on an accepted event:
  - Latch code/PC/addr into the matching port only. The other port's code stays NO_EXC.
  - For mret, set o_mret_e.
  - Assert o_stall and o_flush; go to COMMIT.
- Simultaneous events: only the highest-priority one is accepted. The others are flushed and are not queued.
- COMMIT (1 cycle):
  - The CSR file samples the registered outputs this cycle.
  - At exit, clear codes to NO_EXC and o_mret_e to 0; go to REDIRECT.
- REDIRECT (1 cycle):
  - o_redirect_valid = 1.
  - o_redirect_pc = {i_mtvec[W-1:2], 2'b00} for a trap, or i_mepc for mret (sampled this cycle, after the CSR update).
  - o_flush = 1. Go to HOLDOFF.
- HOLDOFF:
  - o_stall = 0, o_flush = 0.
  - Stay while i_disable_exceptions_1cc = 1; requests arriving in this state are ignored.
  - Return to IDLE when it is 0, with a minimum of 1 cycle.
- Latency: request cycle N → COMMIT outputs valid N+1 → redirect at N+2 → IDLE no earlier than N+4.
- o_busy = (state != IDLE).
- A request code equal to NO_EXC with valid = 1 is treated as no request.

Optional Feature:
- Macro TRAP_SEQ_STATS_EN.
- When defined, add outputs:
  - o_trap_count  out  32  count of accepted traps
  - o_mret_count  out  32  count of accepted mrets
- Both counters increment on IDLE→COMMIT, wrap at 2^32, reset to 0, and hold when i_clk_en = 0.
- When undefined, the ports and logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package/header holds:
  - NO_EXC and the cause codes 0–11.
  - FSM state encodings (2-bit).
  - The W-width macro.
- One natural sub-module: trap_priority_encoder (combinational). It selects the winning event and forms code/pc/addr and is_mret. The FSM and output registers live in trap_sequencer.

Test Plan:
- Reset: hold i_rst=0 for 2 cycles → both codes = 4'd10, all strobes 0, o_busy = 0.
- F/D illegal: i_exc_valid_fd = 1, code 2, pc 0x80000010, mtvec 0x80000101.
  - → next cycle o_exception_code_f_d_ff = 2 and pc = 0x80000010.
  - → following cycle o_redirect_valid = 1, o_redirect_pc = 0x80000100.
- Simultaneous F/D code 2 and E/M code 5 (pc 0x80000020, addr 0x1003) → only the E/M port is latched with 5/0x80000020/0x1003; the F/D code stays 10.
- ecall from U privilege (i_current_privilege = 0) → o_exception_code_f_d_ff = 8; from M privilege → 11.
- mret with i_mepc = 0x80000044 → o_mret_e = 1 for one cycle, then o_redirect_pc = 0x80000044.
- Holdoff: i_disable_exceptions_1cc = 1 for 2 cycles after redirect, with a new request asserted → request ignored and no second COMMIT. Clear i_clk_en mid-COMMIT → state and outputs freeze.
